// File: rtl/texv_stepper.sv
// Texture v stepper for one wall column: step = 2^(5+FRAC)/size by serial divide, start offset by serial multiply.
// Build option TEXV_SAT_EN: accumulator saturates at all-ones instead of wrapping.
module texv_stepper #(
    parameter int H_VIEW = 640,
    parameter int SIZE_W = 11,
    parameter int FRAC   = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [SIZE_W-1:0] size,
    input  logic [9:0]        hpos,
    output logic              busy,
    output logic              ready,
    output logic [5:0]        texv
);
    // state | meaning
    // IDLE  | no line configured since reset
    // DIV   | restoring divide, one quotient bit per clk
    // MUL   | shift-add multiply of (size-HALF) by step
    // RUN   | step valid, accumulating across the span
    localparam int QW   = 6 + FRAC;
    localparam int HALF = H_VIEW / 2;
    localparam int CW   = $clog2((QW > SIZE_W) ? QW : SIZE_W);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] MUL  = 2'd2;
    localparam logic [1:0] RUN  = 2'd3;

    localparam logic [SIZE_W:0] HALF_X   = HALF[SIZE_W:0];
    localparam logic [CW-1:0]   DIV_LAST = CW'(QW - 1);
    localparam logic [CW-1:0]   MUL_LAST = CW'(SIZE_W - 1);

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [SIZE_W-1:0] size_r;
    logic [SIZE_W-1:0] rem;
    logic [QW-1:0]     step;
    logic [QW-1:0]     acc;
    logic [QW-1:0]     mcand;
    logic [SIZE_W-1:0] mplier;

    logic [SIZE_W:0]   size_x;
    logic [SIZE_W:0]   hpos_x;
    logic [SIZE_W:0]   span_start;
    logic [SIZE_W:0]   span_end;
    logic [SIZE_W:0]   trial;
    logic              size_gt_half;
    logic              in_span;
    logic              q_bit;
    logic [SIZE_W-1:0] rem_next;
    logic [SIZE_W-1:0] mul_m;
    logic [QW-1:0]     q_next;
    logic [QW-1:0]     mul_sum;
    logic [QW-1:0]     acc_step;

    always_comb begin
        size_x       = {1'b0, size_r};
        hpos_x       = {{(SIZE_W-9){1'b0}}, hpos};
        size_gt_half = size_x > HALF_X;
        span_start   = size_gt_half ? '0 : HALF_X - size_x;
        span_end     = HALF_X + size_x;
        in_span      = (state == RUN) && (hpos_x >= span_start) && (hpos_x <= span_end);
        // step doubles as the dividend/quotient shift register during DIV
        trial        = {rem, step[QW-1]};
        q_bit        = trial >= size_x;
        rem_next     = q_bit ? SIZE_W'(trial - size_x) : trial[SIZE_W-1:0];
        q_next       = {step[QW-2:0], q_bit};
        mul_m        = SIZE_W'(size_x - HALF_X);
        mul_sum      = acc + (mplier[0] ? mcand : '0);
    end

`ifdef TEXV_SAT_EN
    logic [QW:0] acc_wide;
    always_comb begin
        acc_wide = {1'b0, acc} + {1'b0, step};
        acc_step = acc_wide[QW] ? '1 : acc_wide[QW-1:0];
    end
`else
    assign acc_step = acc + step;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            size_r <= '0;
            rem    <= '0;
            step   <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load) begin
            state  <= DIV;
            cnt    <= DIV_LAST;
            size_r <= size;
            rem    <= '0;
            step   <= {1'b1, {(QW-1){1'b0}}};
        end else begin
            case (state)
                DIV: begin
                    step <= q_next;
                    rem  <= rem_next;
                    cnt  <= cnt - CW'(1);
                    if (cnt == '0) begin
                        state  <= MUL;
                        cnt    <= MUL_LAST;
                        step   <= (size_r == '0) ? '1 : q_next;
                        mcand  <= (size_r == '0) ? '1 : q_next;
                        mplier <= size_gt_half ? mul_m : '0;
                        acc    <= '0;
                    end
                end
                MUL: begin
                    acc    <= mul_sum;
                    mcand  <= {mcand[QW-2:0], 1'b0};
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    if (cnt == '0)
                        state <= RUN;
                end
                RUN: begin
                    if (in_span)
                        acc <= acc_step;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state == DIV) || (state == MUL);
    assign ready = (state == RUN);
    assign texv  = in_span ? acc[QW-1:FRAC] : '0;

endmodule
